// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the writeback load writer.
package wb_pkg;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_REG_ADDR_WIDTH = 5;
    localparam int ZERO_REG = 0;
    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: 8-bit wait counter that flags the last allowed memory wait cycle.
module wb_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    logic [7:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 8'd1;
    end
    assign o_expired = r_cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/wb_load_writer.sv
// wb_load_writer: drives the register-file write port from EX/MEM results,
// stalling upstream while a load waits on the req/ack data memory.
module wb_load_writer
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      ExValid,
    input  logic                      ExRegWrite,
    input  logic                      ExMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] ExWriteReg,
    input  logic [DATA_WIDTH-1:0]     ExAluResult,
    output logic                      MemReq,
    output logic [DATA_WIDTH-1:0]     MemAddr,
    input  logic [DATA_WIDTH-1:0]     MemRdata,
    input  logic                      MemAck,
    output logic                      Stall,
    output logic                      RegWrite,
    output logic [REG_ADDR_WIDTH-1:0] WriteReg,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic                      LoadError
);
    localparam logic [REG_ADDR_WIDTH-1:0] REG0 = REG_ADDR_WIDTH'(ZERO_REG);

    state_t                    r_state, w_state;
    logic                      r_mem_req, w_mem_req;
    logic [DATA_WIDTH-1:0]     r_mem_addr, w_mem_addr;
    logic                      r_reg_write, w_reg_write;
    logic [REG_ADDR_WIDTH-1:0] r_write_reg, w_write_reg;
    logic [DATA_WIDTH-1:0]     r_write_data, w_write_data;
    logic                      r_load_error, w_load_error;
    logic [REG_ADDR_WIDTH-1:0] r_cap_reg, w_cap_reg;
    logic                      r_cap_we, w_cap_we;
    logic                      w_cnt_load, w_cnt_en, w_expired;

    wb_timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_ctr (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_load   (w_cnt_load),
        .i_en     (w_cnt_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_load_error <= 1'b0;
            r_cap_reg    <= '0;
            r_cap_we     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_mem_req    <= w_mem_req;
            r_mem_addr   <= w_mem_addr;
            r_reg_write  <= w_reg_write;
            r_write_reg  <= w_write_reg;
            r_write_data <= w_write_data;
            r_load_error <= w_load_error;
            r_cap_reg    <= w_cap_reg;
            r_cap_we     <= w_cap_we;
        end
    end

    // MemAck is checked before the timeout so a late ack still completes normally.
    always_comb begin
        w_state      = r_state;
        w_mem_req    = r_mem_req;
        w_mem_addr   = r_mem_addr;
        w_reg_write  = 1'b0;
        w_write_reg  = r_write_reg;
        w_write_data = r_write_data;
        w_load_error = 1'b0;
        w_cap_reg    = r_cap_reg;
        w_cap_we     = r_cap_we;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        if (r_state == IDLE) begin
            if (ExValid && ExMemRead) begin
                w_state    = MEM_WAIT;
                w_mem_req  = 1'b1;
                w_mem_addr = ExAluResult;
                w_cap_reg  = ExWriteReg;
                w_cap_we   = ExRegWrite;
                w_cnt_load = 1'b1;
            end else if (ExValid) begin
                w_reg_write  = ExRegWrite && (ExWriteReg != REG0);
                w_write_reg  = ExWriteReg;
                w_write_data = ExAluResult;
            end
        end else if (MemAck) begin
            w_state      = IDLE;
            w_mem_req    = 1'b0;
            w_reg_write  = r_cap_we && (r_cap_reg != REG0);
            w_write_reg  = r_cap_reg;
            w_write_data = MemRdata;
        end else if (w_expired) begin
            w_state      = IDLE;
            w_mem_req    = 1'b0;
            w_load_error = 1'b1;
        end else begin
            w_cnt_en = 1'b1;
        end
    end

    assign Stall     = r_state == MEM_WAIT;
    assign MemReq    = r_mem_req;
    assign MemAddr   = r_mem_addr;
    assign RegWrite  = r_reg_write;
    assign WriteReg  = r_write_reg;
    assign WriteData = r_write_data;
    assign LoadError = r_load_error;
endmodule

// File: tb/tb_wb_load_writer.sv
// tb_wb_load_writer: randomized self-checking bench against a transaction-level
// model of the writeback writer (timeout shortened to 4 cycles).
module tb_wb_load_writer;
    localparam int T  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          ExValid = 1'b0, ExRegWrite = 1'b0, ExMemRead = 1'b0;
    logic [AW-1:0] ExWriteReg = '0;
    logic [DW-1:0] ExAluResult = '0, MemRdata = '0, MemAddr, WriteData;
    logic          MemAck = 1'b0, MemReq, Stall, RegWrite, LoadError;
    logic [AW-1:0] WriteReg;

    wb_load_writer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(T)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExWriteReg(ExWriteReg), .ExAluResult(ExAluResult),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemRdata(MemRdata), .MemAck(MemAck),
        .Stall(Stall), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .LoadError(LoadError)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [AW-1:0] m_reg = '0;
    logic [DW-1:0] m_data = '0;
    wire [40:0] obs = {RegWrite, WriteReg, WriteData, Stall, MemReq, LoadError};
    wire [35:0] wait_obs = {Stall, MemReq, MemAddr, RegWrite, LoadError};

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        n_checks++;
        if ({obs, MemAddr} !== '0) begin
            n_fail++;
            $display("FAIL reset: got %h/%h required 0", obs, MemAddr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [40:0] exp;
        @(negedge Clk);
        ExValid = 1'b0; ExMemRead = 1'($urandom); ExRegWrite = 1'($urandom);
        ExWriteReg = AW'($urandom); ExAluResult = $urandom;
        MemAck = 1'($urandom); MemRdata = $urandom;
        @(posedge Clk); #1;
        exp = {1'b0, m_reg, m_data, 3'b000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL idle: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_alu(input logic [AW-1:0] r, input logic we, input logic [DW-1:0] d);
        logic [40:0] exp;
        @(negedge Clk);
        ExValid = 1'b1; ExMemRead = 1'b0; ExRegWrite = we; ExWriteReg = r; ExAluResult = d;
        MemAck = 1'b0;
        @(posedge Clk); #1;
        m_reg = r;
        m_data = d;
        exp = {we && (r != 0), r, d, 3'b000};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL alu r%0d: got %h required %h", r, obs, exp);
        end
    endtask

    // ack_at = wait cycle (1..T) that carries MemAck, 0 = never acked
    task automatic test_load(input logic [AW-1:0] r, input logic we, input logic [DW-1:0] addr,
                             input logic [DW-1:0] data, input int ack_at);
        logic [40:0] exp;
        logic [35:0] wexp;
        @(negedge Clk);
        ExValid = 1'b1; ExMemRead = 1'b1; ExRegWrite = we; ExWriteReg = r; ExAluResult = addr;
        MemAck = 1'b0;
        @(posedge Clk); #1;
        wexp = {2'b11, addr, 2'b00};
        n_checks++;
        if (wait_obs !== wexp) begin
            n_fail++;
            $display("FAIL load_start: got %h required %h", wait_obs, wexp);
        end
        for (int k = 1; k <= T; k++) begin
            @(negedge Clk);
            ExValid = 1'($urandom); ExMemRead = 1'($urandom); ExRegWrite = 1'($urandom);
            ExWriteReg = AW'($urandom); ExAluResult = $urandom;
            MemAck = (k == ack_at);
            MemRdata = (k == ack_at) ? data : $urandom;
            @(posedge Clk); #1;
            if (k == ack_at) begin
                m_reg = r;
                m_data = data;
                exp = {we && (r != 0), r, data, 3'b000};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL load_ack@%0d: got %h required %h", k, obs, exp);
                end
                break;
            end else if (k == T) begin
                n_checks++;
                if ({RegWrite, Stall, MemReq, LoadError} !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL load_timeout: got %b required 0001",
                             {RegWrite, Stall, MemReq, LoadError});
                end
            end else begin
                n_checks++;
                if (wait_obs !== wexp) begin
                    n_fail++;
                    $display("FAIL load_wait@%0d: got %h required %h", k, wait_obs, wexp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        ExValid = 1'b1; ExMemRead = 1'b1; ExRegWrite = 1'b1; ExWriteReg = 5'd9;
        ExAluResult = 32'h80; MemAck = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        ExValid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({obs, MemAddr} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h required 0", obs, MemAddr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        m_reg = '0;
        m_data = '0;
        test_idle();
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: test_alu(AW'($urandom), 1'($urandom), $urandom);
                1: test_load(AW'($urandom), 1'($urandom), $urandom, $urandom, int'($urandom_range(0, T)));
                default: test_idle();
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_alu(5'd5, 1'b1, 32'h1234);
        test_load(5'd8, 1'b1, 32'h40, 32'hDEADBEEF, 3);
        test_alu(5'd0, 1'b1, 32'hFF);
        test_idle();
        test_load(5'd12, 1'b1, 32'h100, 32'h0BAD_F00D, 0);
        test_idle();
        test_load(5'd3, 1'b1, 32'h44, 32'hCAFE_0001, T);
        test_alu(5'd7, 1'b1, 32'h5555_AAAA);
        test_alu(5'd7, 1'b0, 32'h1111_2222);
        test_alu(5'd31, 1'b1, 32'hFFFF_FFFF);
        test_load(5'd0, 1'b1, 32'h48, 32'h1357_9BDF, 1);
        test_idle();
        test_async_reset();
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
